// File: rtl/mem_bus_master.sv
// Initiator for the 16-bit memory bus: takes single read/write requests from the core
// and runs the address/enable/data bus cycles, returning read data or a write acknowledge.
module mem_bus_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic              mem_enable,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WRITE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              master_drive;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // The request is captured only on acceptance, so anything the core does to req_*
    // while we are busy never reaches the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= req_write ? WRITE : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rsp_rdata <= mem_data;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus strobes are gated by reset so the bus goes quiet in the very cycle reset is asserted.
    assign master_drive   = reset && (state == WRITE);
    assign mem_enable     = reset && (state != IDLE);
    assign mem_read_write = !master_drive;
    assign mem_address    = addr_q;
    assign mem_data       = master_drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a bus responder, a request-level reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized request stream.
module tb_mem_bus_master;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 64;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_address;
    logic        mem_read_write;
    logic        mem_enable;
    wire  [15:0] mem_data;

    always #5 clk = ~clk;

    mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_address   (mem_address),
        .mem_read_write(mem_read_write),
        .mem_enable    (mem_enable),
        .mem_data      (mem_data)
    );

    function automatic logic [15:0] initWord(input int i);
        return (i == 2) ? 16'h5555 : (16'(i * 257) ^ 16'hA5A5);
    endfunction

    // Memory responder: loads its MDR on every enabled read edge, writes on enabled write edges.
    logic [15:0] physMem [MEM_WORDS];
    logic [15:0] mdr       = '0;
    bit          memLoaded = 1'b0;

    assign mem_data = (mem_enable && mem_read_write) ? mdr : 16'bz;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < MEM_WORDS; i++) physMem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end
        if (!reset) mdr <= '0;
        else if (mem_enable) begin
            if (mem_read_write) mdr <= physMem[mem_address[5:0]];
            else physMem[mem_address[5:0]] <= mem_data;
        end
    end

    // Reference model: each accepted request occupies the bus for a fixed number of cycles
    // (read 2, write 1) and its response appears in the first free cycle afterwards.
    logic [15:0] refMem [MEM_WORDS];
    bit          refLoaded   = 1'b0;
    int          remaining   = 0;
    logic        curWrite    = 1'b0;
    logic [15:0] curWdata    = '0;
    logic [15:0] curRdata    = '0;
    logic [15:0] expAddr     = '0;
    logic [15:0] expRdata    = '0;
    logic        expRspValid = 1'b0;
    int          cycleNo     = 0;
    int          acceptCount = 0;

    always @(posedge clk) begin
        cycleNo++;
        if (!refLoaded) begin
            for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initWord(i);
            refLoaded = 1'b1;
        end
        if (!reset) begin
            remaining   = 0;
            expRspValid = 1'b0;
            expRdata    = '0;
            expAddr     = '0;
            curWrite    = 1'b0;
        end else if (remaining > 0) begin
            remaining--;
            expRspValid = (remaining == 0);
            if (remaining == 0 && !curWrite) expRdata = curRdata;
        end else begin
            expRspValid = 1'b0;
            if (req_valid) begin
                curWrite = req_write;
                curWdata = req_wdata;
                expAddr  = req_addr;
                if (req_write) begin
                    refMem[req_addr[5:0]] = req_wdata;
                    remaining = 1;
                end else begin
                    curRdata  = refMem[req_addr[5:0]];
                    remaining = 2;
                end
                acceptCount++;
            end
        end
    end

    int          checks         = 0;
    int          errors         = 0;
    bit          checkEnable    = 1'b0;
    int          rspCount       = 0;
    int          lastRspCycle   = 0;
    int          writeBusCycles = 0;
    int          readBusCycles  = 0;
    int          busyCycles     = 0;
    logic [15:0] seenWrAddr     = '0;
    logic [15:0] seenWrData     = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("req_ready", 32'(req_ready), 32'(remaining == 0));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRspValid));
            checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(expRdata));
            checkOutput("mem_enable", 32'(mem_enable), 32'(reset && remaining > 0));
            checkOutput("mem_read_write", 32'(mem_read_write), 32'(!(reset && remaining > 0 && curWrite)));
            checkOutput("mem_address", 32'(mem_address), 32'(expAddr));
            if (reset && remaining > 0 && curWrite) begin
                checkOutput("write_data", 32'(mem_data), 32'(curWdata));
                writeBusCycles++;
                seenWrAddr = mem_address;
                seenWrData = mem_data;
            end
            if (mem_enable && mem_read_write) begin
                checkOutput("no_contention", 32'(mem_data), 32'(mdr));
                readBusCycles++;
            end
            if (rsp_valid) begin
                rspCount++;
                lastRspCycle = cycleNo;
            end
            if (reset && !req_ready) busyCycles++;
        end
    end

    task automatic applyStimulus(input logic valid, input logic write, input logic [15:0] addr,
                                 input logic [15:0] wdata);
        req_valid = valid;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic clearCounters();
        rspCount       = 0;
        writeBusCycles = 0;
        readBusCycles  = 0;
        busyCycles     = 0;
        acceptCount    = 0;
    endtask

    // Holds a request until the cycle it is accepted; returns that cycle's number.
    task automatic issueRequest(input logic write, input logic [15:0] addr, input logic [15:0] wdata,
                                output int acceptCycle);
        bit done = 1'b0;
        acceptCycle = -1;
        applyStimulus(1'b1, write, addr, wdata);
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acceptCycle = cycleNo;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("accept_in_time", 32'(done), 32'(1));
    endtask

    int accA;
    int accB;

    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b1;
        checkEnable = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("t1_ready", 32'(req_ready), 32'(1));
        checkOutput("t1_enable", 32'(mem_enable), 32'(0));
        checkOutput("t1_rw", 32'(mem_read_write), 32'(1));
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("t1_rsp_rdata", 32'(rsp_rdata), 32'(0));
        checkOutput("t1_address", 32'(mem_address), 32'(0));
        @(posedge clk);
        #1;

        // Single write
        clearCounters();
        issueRequest(1'b1, 16'h0010, 16'hBEEF, accA);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t2_latency", 32'(lastRspCycle - accA), 32'(2));
        checkOutput("t2_write_cycles", 32'(writeBusCycles), 32'(1));
        checkOutput("t2_busy_cycles", 32'(busyCycles), 32'(1));
        checkOutput("t2_bus_addr", 32'(seenWrAddr), 32'h0010);
        checkOutput("t2_bus_data", 32'(seenWrData), 32'hBEEF);
        checkOutput("t2_rsp_count", 32'(rspCount), 32'(1));

        // Read back
        clearCounters();
        issueRequest(1'b0, 16'h0010, 16'h0000, accA);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3_latency", 32'(lastRspCycle - accA), 32'(3));
        checkOutput("t3_read_cycles", 32'(readBusCycles), 32'(2));
        checkOutput("t3_busy_cycles", 32'(busyCycles), 32'(2));
        checkOutput("t3_rdata_held", 32'(rsp_rdata), 32'hBEEF);

        // Back-to-back write then read with req_valid held
        clearCounters();
        issueRequest(1'b1, 16'h0001, 16'h1234, accA);
        issueRequest(1'b0, 16'h0001, 16'h0000, accB);
        checkOutput("t4_accept_in_rsp_cycle", 32'(accB), 32'(lastRspCycle));
        checkOutput("t4_accept_gap", 32'(accB - accA), 32'(2));
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t4_rdata", 32'(rsp_rdata), 32'h1234);
        checkOutput("t4_rsp_count", 32'(rspCount), 32'(2));

        // Reset during the data phase of a read
        clearCounters();
        issueRequest(1'b0, 16'h0002, 16'h0000, accA);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_enable_in_reset", 32'(mem_enable), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_rdata_cleared", 32'(rsp_rdata), 32'(0));
        checkOutput("t5_ready", 32'(req_ready), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_no_rsp", 32'(rspCount), 32'(0));
        issueRequest(1'b0, 16'h0002, 16'h0000, accA);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5_reread", 32'(rsp_rdata), 32'h5555);

        // Random stream: inputs change every cycle, busy or not
        clearCounters();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom));
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_rsp_per_accept", 32'(rspCount), 32'(acceptCount));

        checkEnable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
